// File: rtl/tennis_pkg.sv
// Shared encodings and defaults for the tennis match controller.
// Sources of the FSM state, court side and step-period constants.
package tennis_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_SERVE = 3'd1,
      RALLY      = 3'd2,
      POINT      = 3'd3,
      MATCH_OVER = 3'd4
   } state_t;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } side_t;

   localparam int unsigned PERIOD_W       = 22;
   localparam int unsigned DEF_TICK_INIT  = 3531008;
   localparam int unsigned DEF_TICK_STEP  = 8191;
   localparam int unsigned DEF_TICK_MIN   = 500000;
   localparam logic [3:0]  SCORE_MAX      = 4'd15;

   // Scores stick at the top of their 4-bit range instead of wrapping.
   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s == SCORE_MAX) ? s : s + 4'd1;
   endfunction

endpackage

// File: rtl/tennis_step_timer.sv
// Ball step period counter: emits a one-cycle tick every 'period' clocks
// and shortens the period after each point down to a floor.
module tennis_step_timer
   import tennis_pkg::*;
#(
   parameter int unsigned TICK_INIT = DEF_TICK_INIT,
   parameter int unsigned TICK_STEP = DEF_TICK_STEP,
   parameter int unsigned TICK_MIN  = DEF_TICK_MIN
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                clear,
   input  logic                dec,
   output logic                tick,
   output logic [PERIOD_W-1:0] period
);

   localparam logic [PERIOD_W-1:0] INIT_P = PERIOD_W'(TICK_INIT);
   localparam logic [PERIOD_W-1:0] STEP_P = PERIOD_W'(TICK_STEP);
   localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(TICK_MIN);
   localparam logic [PERIOD_W-1:0] ONE    = PERIOD_W'(1);

   logic [PERIOD_W-1:0] cnt;

   // Wrap on >= so a period shortened mid-count can never strand the counter above it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         tick   <= 1'b0;
         period <= INIT_P;
      end else begin
         tick <= 1'b0;
         if (clear || !run) begin
            cnt <= '0;
         end else if (cnt >= period - ONE) begin
            cnt  <= '0;
            tick <= 1'b1;
         end else begin
            cnt <= cnt + ONE;
         end

         if (clear) begin
            period <= INIT_P;
         end else if (dec) begin
            period <= (period >= MIN_P + STEP_P) ? period - STEP_P : MIN_P;
         end
      end
   end

endmodule

// File: rtl/tennis_match_ctrl.sv
// Match-level sequencer: serve, rally pacing, scoring, server swap, winner.
// Define TENNIS_DEUCE_EN to require a two-point lead (with 15-15 reload).
module tennis_match_ctrl
   import tennis_pkg::*;
#(
   parameter int unsigned TICK_INIT     = DEF_TICK_INIT,
   parameter int unsigned TICK_STEP     = DEF_TICK_STEP,
   parameter int unsigned TICK_MIN      = DEF_TICK_MIN,
   parameter int unsigned SERVE_TIMEOUT = 2000,
   parameter int unsigned POINT_HOLD    = 4,
   parameter int unsigned WIN_POINTS    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic       step_en,
   output logic       serve_go,
   output logic       serve_side,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic       match_over,
   output logic       winner,
   output logic [2:0] state_o
);

   localparam logic [3:0]  WIN        = 4'(WIN_POINTS);
   localparam logic [15:0] SERVE_LAST = 16'(SERVE_TIMEOUT - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(POINT_HOLD - 1);

   state_t              state;
   side_t               server;
   logic [15:0]         tick_cnt;
   logic                tick;
   logic                run;
   logic                clear;
   logic                any_miss;
   logic                dec;
   logic                serve_req;
   logic                left_wins;
   logic                right_wins;
   logic [3:0]          next_left;
   logic [3:0]          next_right;
   logic [PERIOD_W-1:0] period;

   assign run       = (state == WAIT_SERVE) || (state == RALLY) || (state == POINT);
   assign clear     = start && ((state == IDLE) || (state == MATCH_OVER));
   assign any_miss  = miss_left || miss_right;
   assign dec       = (state == RALLY) && any_miss;
   assign step_en   = tick && (state == RALLY);
   assign state_o   = state;
   assign serve_req = ((server == LEFT) ? btn_left : btn_right) ||
                      (tick && (tick_cnt == SERVE_LAST));

   tennis_step_timer #(
      .TICK_INIT (TICK_INIT),
      .TICK_STEP (TICK_STEP),
      .TICK_MIN  (TICK_MIN)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .run    (run),
      .clear  (clear),
      .dec    (dec),
      .tick   (tick),
      .period (period)
   );

   // A simultaneous double miss is a let: nobody scores.
   always_comb begin
      next_left  = score_left;
      next_right = score_right;
      if (miss_right && !miss_left) next_left  = sat_inc(score_left);
      if (miss_left && !miss_right) next_right = sat_inc(score_right);
`ifdef TENNIS_DEUCE_EN
      if ((next_left == SCORE_MAX) && (next_right == SCORE_MAX)) begin
         next_left  = 4'(WIN_POINTS - 1);
         next_right = 4'(WIN_POINTS - 1);
      end
`endif
   end

`ifdef TENNIS_DEUCE_EN
   assign left_wins  = (score_left >= WIN) &&
                       ({1'b0, score_left} >= {1'b0, score_right} + 5'd2);
   assign right_wins = (score_right >= WIN) &&
                       ({1'b0, score_right} >= {1'b0, score_left} + 5'd2);
`else
   assign left_wins  = (score_left >= WIN);
   assign right_wins = (score_right >= WIN);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         server      <= LEFT;
         tick_cnt    <= '0;
         serve_go    <= 1'b0;
         serve_side  <= 1'b0;
         score_left  <= '0;
         score_right <= '0;
         match_over  <= 1'b0;
         winner      <= 1'b0;
      end else begin
         serve_go <= 1'b0;
         case (state)
            IDLE, MATCH_OVER: begin
               if (start) begin
                  score_left  <= '0;
                  score_right <= '0;
                  server      <= LEFT;
                  tick_cnt    <= '0;
                  match_over  <= 1'b0;
                  winner      <= 1'b0;
                  state       <= WAIT_SERVE;
               end
            end
            WAIT_SERVE: begin
               if (serve_req) begin
                  serve_go   <= 1'b1;
                  serve_side <= server;
                  tick_cnt   <= '0;
                  state      <= RALLY;
               end else if (tick) begin
                  tick_cnt <= tick_cnt + 16'd1;
               end
            end
            RALLY: begin
               if (any_miss) begin
                  score_left  <= next_left;
                  score_right <= next_right;
                  server      <= (server == LEFT) ? RIGHT : LEFT;
                  tick_cnt    <= '0;
                  state       <= POINT;
               end
            end
            POINT: begin
               if (tick) begin
                  if (tick_cnt == HOLD_LAST) begin
                     tick_cnt <= '0;
                     if (left_wins) begin
                        match_over <= 1'b1;
                        winner     <= LEFT;
                        state      <= MATCH_OVER;
                     end else if (right_wins) begin
                        match_over <= 1'b1;
                        winner     <= RIGHT;
                        state      <= MATCH_OVER;
                     end else begin
                        state <= WAIT_SERVE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 16'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/tennis_match_ctrl.md
Name: tennis_match_ctrl

Overview:
- Match-level sequencer for the tennis ball-mover datapath.
- Generates the ball step enable (rally speed), issues serve commands, consumes miss events, keeps score, alternates server, declares the match winner.
- Sits between the debounced player buttons and the ball datapath/LED display logic.

Parameters:
- TICK_INIT, 3531008: initial clocks per ball step.
- TICK_STEP, 8191: period reduction applied after each point.
- TICK_MIN, 500000: floor on the step period.
- SERVE_TIMEOUT, 2000: step periods in WAIT_SERVE before the server auto-serves.
- POINT_HOLD, 4: step periods spent in POINT before the next serve.
- WIN_POINTS, 3: points needed to win the match (max 15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new match from IDLE or MATCH_OVER.
- btn_left  in  1  debounced left-player press, single-cycle pulse.
- btn_right  in  1  debounced right-player press, single-cycle pulse.
- miss_left  in  1  pulse from datapath: left player missed.
- miss_right  in  1  pulse from datapath: right player missed.
- step_en  out  1  one-cycle pulse per ball step; asserted only in RALLY.
- serve_go  out  1  one-cycle pulse; datapath loads the ball at the server's end.
- serve_side  out  1  0 = left serves, 1 = right serves; valid while serve_go=1, held otherwise.
- score_left  out  4  left points.
- score_right  out  4  right points.
- match_over  out  1  high in MATCH_OVER.
- winner  out  1  0 = left, 1 = right; valid while match_over=1.
- state_o  out  3  current FSM state encoding, for the display.

Behaviour:
- Reset: state IDLE.
  - All outputs 0; period register = TICK_INIT; all counters 0; server = left.
- States (3-bit): IDLE=0, WAIT_SERVE=1, RALLY=2, POINT=3, MATCH_OVER=4.
- Period counter (22-bit):
  - Free-runs in WAIT_SERVE, RALLY and POINT; held at 0 elsewhere.
  - On reaching period-1: wraps to 0 and raises internal tick for one cycle.
  - step_en = tick AND state==RALLY.
- IDLE or MATCH_OVER + start:
  - Clear scores, period=TICK_INIT, server=left, period counter=0.
  - Go to WAIT_SERVE next cycle.
- WAIT_SERVE:
  - Server's button press: serve_go=1 for one cycle, serve_side=server, then RALLY.
  - Receiver's button is ignored.
  - serve_timer counts ticks; at SERVE_TIMEOUT ticks, auto-serve identically to a press.
  - serve_timer clears on exit.
- RALLY:
  - miss_left: score_right+1, go to POINT.
  - miss_right: score_left+1, go to POINT.
  - Both misses in the same cycle: no score change, go to POINT (let).
  - Buttons are ignored by this block (the datapath handles returns).
- POINT:
  - On entry: server toggles; period = max(period-TICK_STEP, TICK_MIN). Subtraction is checked before applying, so the period never underflows.
  - After POINT_HOLD ticks: if either score ≥ WIN_POINTS → MATCH_OVER, winner = the side that reached it; else → WAIT_SERVE.
- Scores saturate at 15.
- Miss pulses outside RALLY are ignored.
- start outside IDLE/MATCH_OVER is ignored.
- reset mid-operation: returns to IDLE on the next edge regardless of state; any pending serve_go is dropped.
- Latency: button press → serve_go on the next clock edge. Miss → score update on the next clock edge.

Optional Feature:
- Macro TENNIS_DEUCE_EN.
- Defined: the win condition requires score ≥ WIN_POINTS and a lead of at least 2. If both scores reach 15, both reload to WIN_POINTS-1 on the same edge, so the match can continue.
- Undefined: first to WIN_POINTS wins. A 2-point lead is not required.

Decomposition:
- Package tennis_pkg holds:
  - FSM state encoding constants.
  - Side encoding (LEFT=0, RIGHT=1).
  - Default TICK_INIT/TICK_STEP/TICK_MIN constants.
- Sub-module tennis_step_timer holds the period counter and the saturating period decrement. Outputs: tick, and the current period for debug.

Test Plan (TICK_INIT=10, TICK_STEP=2, TICK_MIN=4, SERVE_TIMEOUT=5, POINT_HOLD=2, WIN_POINTS=3):
- reset, start, btn_left → serve_go=1 with serve_side=0 one cycle after press; step_en every 10 clocks in RALLY.
- start, no press → auto-serve serve_go exactly after 5 ticks (50 clocks); btn_right beforehand has no effect.
- Rally, miss_right → score_left=1; after 2 ticks, WAIT_SERVE with server=right; step period now 8.
- Repeat points until the period would drop below 4 → period clamps at 4 and never underflows.
- Left scores 3 → match_over=1, winner=0, step_en stays low; start → scores 0, period 10.
- miss_left and miss_right in the same cycle → scores unchanged, POINT entered. Separately: reset asserted during RALLY → IDLE and all outputs 0 next edge.
